difftest_sim_ctrl: RTL and testbench
====================================

Name: difftest_sim_ctrl

Overview:
Synthesizable, multi-core simulation-control endpoint for emulation and FPGA difftest builds, where DPI-C and $finish are unavailable.
Aggregates per-core commit steps and exit codes, runs watchdogs (max-cycle, per-core stuck), detects warmup completion, and drives perf clean/dump.
Merges per-core UART byte streams into one buffered, back-pressured output for the host bridge.
Sits at the top of the DUT harness, between the cores' difftest IO and the host transport.

Parameters:
NUM_CORES, 2, number of cores (1..8)
STEP_WIDTH, 8, per-core commit-step width
STUCK_W, 32, stuck timer/limit width
UART_DEPTH, 16, shared UART FIFO entries (power of 2, >=2)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_max_cycles  in  64  0 = unlimited
cfg_stuck_limit  in  STUCK_W  0 = disabled
cfg_warmup_instr  in  64  0 = no warmup
core_step  in  NUM_CORES*STEP_WIDTH  instructions committed this cycle, per core
core_exit  in  NUM_CORES*64  per-core exit code (0 run, all-ones good, else error)
core_uart_valid  in  NUM_CORES  per-core UART byte valid (no back-pressure)
core_uart_ch  in  NUM_CORES*8  per-core UART byte
uart_out_valid  out  1  merged UART byte valid
uart_out_ready  in  1  host accepts byte
uart_out_ch  out  8  byte
uart_out_core  out  $clog2(NUM_CORES) (min 1)  source core
uart_drop_cnt  out  16  saturating count of dropped bytes
n_cycles  out  64  cycles since reset release
instr_count  out  64  total committed instructions, all cores
sim_state  out  2  IDLE=0, RUN=1, DONE=2, FAIL=3
fail_cause  out  2  0 none, 1 exit error, 2 stuck, 3 max cycles
fail_core  out  $clog2(NUM_CORES) (min 1)  offending core (0 for max cycles)
fail_exit_code  out  64  captured error exit code
perf_clean  out  1  one-cycle pulse
perf_dump  out  1  one-cycle pulse

Behaviour:
- Reset: every output and all internal state are 0; sim_state = IDLE; the FIFO is empty.
- FSM:
  - IDLE -> RUN on the first clock after reset deasserts.
  - RUN -> FAIL or DONE as defined below.
  - DONE and FAIL are terminal until reset.
- n_cycles increments every cycle in RUN and freezes in DONE/FAIL.
- instr_count accumulates the sum of all core_step each RUN cycle (sum is zero-extended), saturating at 2^64-1.
- Warmup: when cfg_warmup_instr != 0, perf_clean pulses for one cycle on the first cycle where the registered instr_count >= cfg_warmup_instr. It fires at most once per reset.
- Per-core good flag: set sticky when core_exit == all-ones.
- DONE: entered when all good flags are set, or will be set by this cycle's exit values.
- Per-core stuck timer:
  - Clears when the core's step != 0 or the core is good; otherwise increments, saturating.
  - Fail condition: cfg_stuck_limit != 0 and timer >= cfg_stuck_limit.
- Max-cycle fail: cfg_max_cycles != 0 and n_cycles >= cfg_max_cycles.
- Priority within one RUN cycle:
  1. exit error (lowest core index wins)
  2. stuck (lowest index)
  3. max cycles
  4. DONE
- fail_cause, fail_core and fail_exit_code are registered on the FAIL transition and held.
- perf_dump pulses for one cycle on the cycle sim_state first shows DONE or FAIL.
- UART:
  - One 1-entry skid register per core. A valid byte is captured into an empty skid.
  - A byte arriving while the skid is full is dropped and uart_drop_cnt increments, saturating at 0xFFFF.
  - A round-robin arbiter moves at most one skid into the FIFO per cycle, only when the FIFO is not full. Priority starts after the last-granted core.
  - A skid may be drained and refilled in the same cycle.
  - FIFO output is first-word-fall-through. Handshake is valid && ready. Simultaneous push and pop while full is legal only with a pop, so a full FIFO with a pop accepts the push.
  - UART capture continues in DONE/FAIL so final prints drain.
- Latency: core byte to uart_out_valid is a minimum of 2 cycles (skid, then FIFO).

Decomposition:
- Package difftest_sim_ctrl_pkg holds:
  - sim_state_e (IDLE/RUN/DONE/FAIL) and fail_cause_e enums
  - EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF
  - the clog2-min-1 width helper function
- Sub-module difftest_uart_merge contains the skids, round-robin arbiter, FIFO and drop counter. It is parametrised by NUM_CORES and UART_DEPTH.

Test Plan:
- NUM_CORES=2. Core0 exit all-ones at cycle 10, core1 at cycle 20 -> sim_state=DONE exactly after core1's exit; perf_dump one pulse; n_cycles frozen at 20.
- Core1 exit=0x5 while core0 stuck timer also at limit in the same cycle -> FAIL, fail_cause=1, fail_core=1, fail_exit_code=0x5.
- cfg_stuck_limit=100, core0 steps 0 continuously, core1 steps every cycle -> FAIL with cause 2, core 0, on the cycle the timer reaches 100; core1 unaffected.
- cfg_warmup_instr=50, both cores step 3 per cycle -> single perf_clean pulse when instr_count first reaches >=50 (after 9 cycles: 54); no further pulses.
- cfg_max_cycles=1000, no exits, steps nonzero -> FAIL cause 3, fail_core=0 at n_cycles=1000.
- Both cores send bytes every cycle, uart_out_ready held low for 30 cycles -> FIFO fills to 16; each skid keeps 1 byte; uart_drop_cnt counts the rest. After ready rises, output alternates core0/core1 and FIFO order is preserved.

Source files
------------

// File: rtl/difftest_sim_ctrl_pkg.sv
// Shared types and helpers for the difftest simulation-control endpoint.
// Holds the run-state and failure-cause encodings seen by the host bridge.
package difftest_sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } sim_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_EXIT   = 2'd1,
    CAUSE_STUCK  = 2'd2,
    CAUSE_MAXCYC = 2'd3
  } fail_cause_e;

  localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  // Index width for a core count; a single core still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/difftest_uart_merge.sv
// Merges per-core UART byte streams through 1-entry skids, a round-robin
// arbiter and a shared first-word-fall-through FIFO toward the host bridge.
module difftest_uart_merge
  import difftest_sim_ctrl_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int UART_DEPTH = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CORES-1:0]               i_uart_valid,
  input  logic [NUM_CORES*8-1:0]             i_uart_ch,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [7:0]                         o_ch,
  output logic [clog2_min1(NUM_CORES)-1:0]   o_core,
  output logic [15:0]                        o_drop_cnt
);

  localparam int CW = clog2_min1(NUM_CORES);
  localparam int AW = $clog2(UART_DEPTH);

  logic [NUM_CORES-1:0] r_skid_valid;
  logic [7:0]           r_skid_ch [NUM_CORES];
  logic [CW-1:0]        r_last_grant;
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [7:0]           r_mem_ch [UART_DEPTH];
  logic [CW-1:0]        r_mem_core [UART_DEPTH];
  logic [15:0]          r_drop_cnt;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_grant_any;
  logic [CW-1:0]        w_grant_idx;
  logic [CW-1:0]        w_cand;
  logic [NUM_CORES-1:0] w_drain;
  logic [NUM_CORES-1:0] w_drop;
  logic [16:0]          w_drop_sum;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = o_valid && i_ready;

  assign o_valid    = !w_empty;
  assign o_ch       = r_mem_ch[r_rd_ptr[AW-1:0]];
  assign o_core     = r_mem_core[r_rd_ptr[AW-1:0]];
  assign o_drop_cnt = r_drop_cnt;

  // Search starts one past the last granted core; a full FIFO still takes a
  // push when the head is leaving in the same cycle.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_cand = CW'((int'(r_last_grant) + k) % NUM_CORES);
      if (!w_grant_any && r_skid_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    w_push = w_grant_any && (!w_full || w_pop);
  end

  always_comb begin
    w_drain = '0;
    w_drop  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_drain[i] = w_push && (w_grant_idx == CW'(i));
      w_drop[i]  = i_uart_valid[i] && r_skid_valid[i] && !w_drain[i];
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'($countones(w_drop));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_skid_valid <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_skid_ch[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (i_uart_valid[i] && (!r_skid_valid[i] || w_drain[i])) begin
          r_skid_valid[i] <= 1'b1;
          r_skid_ch[i]    <= i_uart_ch[i*8 +: 8];
        end else if (w_drain[i]) begin
          r_skid_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_grant <= '0;
      for (int j = 0; j < UART_DEPTH; j++) begin
        r_mem_ch[j]   <= '0;
        r_mem_core[j] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_ch[r_wr_ptr[AW-1:0]]   <= r_skid_ch[w_grant_idx];
        r_mem_core[r_wr_ptr[AW-1:0]] <= w_grant_idx;
        r_wr_ptr                     <= r_wr_ptr + 1'b1;
        r_last_grant                 <= w_grant_idx;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_drop_cnt <= '0;
    else       r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

endmodule

// File: rtl/difftest_sim_ctrl.sv
// Simulation-control endpoint: run/done/fail sequencing, watchdogs, warmup
// and perf pulses, plus the merged UART path for the host bridge.
module difftest_sim_ctrl
  import difftest_sim_ctrl_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int STEP_WIDTH = 8,
  parameter int STUCK_W    = 32,
  parameter int UART_DEPTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [63:0]                         cfg_max_cycles,
  input  logic [STUCK_W-1:0]                  cfg_stuck_limit,
  input  logic [63:0]                         cfg_warmup_instr,
  input  logic [NUM_CORES*STEP_WIDTH-1:0]     core_step,
  input  logic [NUM_CORES*64-1:0]             core_exit,
  input  logic [NUM_CORES-1:0]                core_uart_valid,
  input  logic [NUM_CORES*8-1:0]              core_uart_ch,
  output logic                                uart_out_valid,
  input  logic                                uart_out_ready,
  output logic [7:0]                          uart_out_ch,
  output logic [clog2_min1(NUM_CORES)-1:0]    uart_out_core,
  output logic [15:0]                         uart_drop_cnt,
  output logic [63:0]                         n_cycles,
  output logic [63:0]                         instr_count,
  output logic [1:0]                          sim_state,
  output logic [1:0]                          fail_cause,
  output logic [clog2_min1(NUM_CORES)-1:0]    fail_core,
  output logic [63:0]                         fail_exit_code,
  output logic                                perf_clean,
  output logic                                perf_dump
);

  localparam int CW    = clog2_min1(NUM_CORES);
  localparam int SUM_W = STEP_WIDTH + CW + 1;

  sim_state_e           r_state;
  fail_cause_e          r_fail_cause;
  logic [CW-1:0]        r_fail_core;
  logic [63:0]          r_fail_code;
  logic [63:0]          r_ncycles;
  logic [63:0]          r_instr;
  logic [NUM_CORES-1:0] r_good;
  logic                 r_perf_dump;
  logic                 r_warm_done;
  logic [STUCK_W-1:0]   r_stuck_timer [NUM_CORES];

  logic [SUM_W-1:0]     w_step_sum;
  logic [64:0]          w_instr_sum;
  logic [63:0]          w_instr_next;
  logic [NUM_CORES-1:0] w_exit_good;
  logic [NUM_CORES-1:0] w_exit_err;
  logic [NUM_CORES-1:0] w_stuck;
  logic [NUM_CORES-1:0] w_step_nz;
  logic                 w_err_any;
  logic [CW-1:0]        w_err_idx;
  logic [63:0]          w_err_code;
  logic                 w_stuck_any;
  logic [CW-1:0]        w_stuck_idx;
  logic                 w_max_hit;
  logic                 w_all_good;
  logic                 w_clean;

  always_comb begin
    w_step_sum  = '0;
    w_exit_good = '0;
    w_exit_err  = '0;
    w_stuck     = '0;
    w_step_nz   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_step_sum     = w_step_sum + SUM_W'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
      w_step_nz[i]   = (core_step[i*STEP_WIDTH +: STEP_WIDTH] != '0);
      w_exit_good[i] = (core_exit[i*64 +: 64] == EXIT_GOOD);
      w_exit_err[i]  = (core_exit[i*64 +: 64] != 64'd0) && !w_exit_good[i];
      w_stuck[i]     = (cfg_stuck_limit != '0) && (r_stuck_timer[i] >= cfg_stuck_limit);
    end
    w_instr_sum  = {1'b0, r_instr} + 65'(w_step_sum);
    w_instr_next = w_instr_sum[64] ? '1 : w_instr_sum[63:0];
  end

  // Lowest-index core wins among simultaneous exit errors or stuck cores.
  always_comb begin
    w_err_any   = 1'b0;
    w_err_idx   = '0;
    w_err_code  = '0;
    w_stuck_any = 1'b0;
    w_stuck_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_err_any && w_exit_err[i]) begin
        w_err_any  = 1'b1;
        w_err_idx  = CW'(i);
        w_err_code = core_exit[i*64 +: 64];
      end
      if (!w_stuck_any && w_stuck[i]) begin
        w_stuck_any = 1'b1;
        w_stuck_idx = CW'(i);
      end
    end
    w_max_hit  = (cfg_max_cycles != 64'd0) && (r_ncycles >= cfg_max_cycles);
    w_all_good = &(r_good | w_exit_good);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ncycles    <= '0;
      r_instr      <= '0;
      r_good       <= '0;
      r_fail_cause <= CAUSE_NONE;
      r_fail_core  <= '0;
      r_fail_code  <= '0;
      r_perf_dump  <= 1'b0;
    end else begin
      r_perf_dump <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN: begin
          r_ncycles <= r_ncycles + 64'd1;
          r_instr   <= w_instr_next;
          r_good    <= r_good | w_exit_good;
          if (w_err_any) begin
            r_state      <= ST_FAIL;
            r_fail_cause <= CAUSE_EXIT;
            r_fail_core  <= w_err_idx;
            r_fail_code  <= w_err_code;
            r_perf_dump  <= 1'b1;
          end else if (w_stuck_any) begin
            r_state      <= ST_FAIL;
            r_fail_cause <= CAUSE_STUCK;
            r_fail_core  <= w_stuck_idx;
            r_perf_dump  <= 1'b1;
          end else if (w_max_hit) begin
            r_state      <= ST_FAIL;
            r_fail_cause <= CAUSE_MAXCYC;
            r_fail_core  <= '0;
            r_perf_dump  <= 1'b1;
          end else if (w_all_good) begin
            r_state     <= ST_DONE;
            r_perf_dump <= 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // A core that has exited good must never trip the stuck watchdog.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) r_stuck_timer[i] <= '0;
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_step_nz[i] || r_good[i] || w_exit_good[i])
          r_stuck_timer[i] <= '0;
        else if (r_stuck_timer[i] != '1)
          r_stuck_timer[i] <= r_stuck_timer[i] + STUCK_W'(1);
      end
    end
  end

  assign w_clean = (cfg_warmup_instr != 64'd0) && (r_instr >= cfg_warmup_instr) && !r_warm_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_warm_done <= 1'b0;
    else if (w_clean) r_warm_done <= 1'b1;
  end

  assign n_cycles       = r_ncycles;
  assign instr_count    = r_instr;
  assign sim_state      = r_state;
  assign fail_cause     = r_fail_cause;
  assign fail_core      = r_fail_core;
  assign fail_exit_code = r_fail_code;
  assign perf_clean     = w_clean;
  assign perf_dump      = r_perf_dump;

  difftest_uart_merge #(
    .NUM_CORES  (NUM_CORES),
    .UART_DEPTH (UART_DEPTH)
  ) u_uart_merge (
    .clock        (clock),
    .reset        (reset),
    .i_uart_valid (core_uart_valid),
    .i_uart_ch    (core_uart_ch),
    .o_valid      (uart_out_valid),
    .i_ready      (uart_out_ready),
    .o_ch         (uart_out_ch),
    .o_core       (uart_out_core),
    .o_drop_cnt   (uart_drop_cnt)
  );

endmodule

// File: tb/tb_difftest_sim_ctrl.sv
// Directed bench for difftest_sim_ctrl with two cores: completion, failure
// priorities, watchdogs, warmup pulse and the merged UART path.
module tb_difftest_sim_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  cfg_max_cycles = '0;
  logic [31:0]  cfg_stuck_limit = '0;
  logic [63:0]  cfg_warmup_instr = '0;
  logic [15:0]  core_step = '0;
  logic [127:0] core_exit = '0;
  logic [1:0]   core_uart_valid = '0;
  logic [15:0]  core_uart_ch = '0;
  logic         uart_out_ready = 1'b0;
  logic         uart_out_valid;
  logic [7:0]   uart_out_ch;
  logic [0:0]   uart_out_core;
  logic [15:0]  uart_drop_cnt;
  logic [63:0]  n_cycles;
  logic [63:0]  instr_count;
  logic [1:0]   sim_state;
  logic [1:0]   fail_cause;
  logic [0:0]   fail_core;
  logic [63:0]  fail_exit_code;
  logic         perf_clean;
  logic         perf_dump;

  int checks = 0;
  int failures = 0;
  int pulses;
  logic [63:0] pulseInstr;

  difftest_sim_ctrl #(
    .NUM_CORES  (2),
    .STEP_WIDTH (8),
    .STUCK_W    (32),
    .UART_DEPTH (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cfg_max_cycles   (cfg_max_cycles),
    .cfg_stuck_limit  (cfg_stuck_limit),
    .cfg_warmup_instr (cfg_warmup_instr),
    .core_step        (core_step),
    .core_exit        (core_exit),
    .core_uart_valid  (core_uart_valid),
    .core_uart_ch     (core_uart_ch),
    .uart_out_valid   (uart_out_valid),
    .uart_out_ready   (uart_out_ready),
    .uart_out_ch      (uart_out_ch),
    .uart_out_core    (uart_out_core),
    .uart_drop_cnt    (uart_drop_cnt),
    .n_cycles         (n_cycles),
    .instr_count      (instr_count),
    .sim_state        (sim_state),
    .fail_cause       (fail_cause),
    .fail_core        (fail_core),
    .fail_exit_code   (fail_exit_code),
    .perf_clean       (perf_clean),
    .perf_dump        (perf_dump)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reset, load configuration, release; returns at the negedge after IDLE->RUN.
  task automatic applyStimulus(input logic [63:0] maxc, input logic [31:0] stuck, input logic [63:0] warm);
    reset            = 1'b1;
    cfg_max_cycles   = maxc;
    cfg_stuck_limit  = stuck;
    cfg_warmup_instr = warm;
    core_step        = '0;
    core_exit        = '0;
    core_uart_valid  = '0;
    core_uart_ch     = '0;
    uart_out_ready   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitForCycle(input logic [63:0] target, input int budget, input string tag);
    int n = 0;
    while (n_cycles !== target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, n_cycles, target);
  endtask

  initial begin
    // Reset values, with nonzero steps present while in reset.
    core_step = 16'h0303;
    repeat (2) @(negedge clock);
    checkOutput("rst_state", sim_state, 2'd0);
    checkOutput("rst_ncycles", n_cycles, 64'd0);
    checkOutput("rst_instr", instr_count, 64'd0);
    checkOutput("rst_uart_valid", uart_out_valid, 1'b0);
    checkOutput("rst_drop", uart_drop_cnt, 16'd0);
    checkOutput("rst_cause", fail_cause, 2'd0);
    checkOutput("rst_dump", perf_dump, 1'b0);
    checkOutput("rst_clean", perf_clean, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_to_run", sim_state, 2'd1);
    checkOutput("idle_no_count", n_cycles, 64'd0);
    checkOutput("idle_no_instr", instr_count, 64'd0);
    @(negedge clock);
    checkOutput("first_instr", instr_count, 64'd6);

    // Both cores exit good: core0 in cycle 10, core1 in cycle 20.
    applyStimulus(64'd0, 32'd0, 64'd0);
    core_step = 16'h0101;
    waitForCycle(64'd9, 40, "done_reach9");
    core_exit[63:0] = '1;
    waitForCycle(64'd19, 40, "done_reach19");
    checkOutput("done_still_run", sim_state, 2'd1);
    core_exit[127:64] = '1;
    @(negedge clock);
    checkOutput("done_state", sim_state, 2'd2);
    checkOutput("done_ncycles", n_cycles, 64'd20);
    checkOutput("done_instr", instr_count, 64'd40);
    checkOutput("done_dump_pulse", perf_dump, 1'b1);
    @(negedge clock);
    checkOutput("done_dump_low", perf_dump, 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("done_frozen", n_cycles, 64'd20);
    checkOutput("done_held", sim_state, 2'd2);

    // Exit error on core1 in the same cycle core0's stuck timer hits its limit.
    applyStimulus(64'd0, 32'd5, 64'd0);
    core_step = 16'h0100;
    waitForCycle(64'd5, 20, "exit_reach5");
    checkOutput("exit_pre_run", sim_state, 2'd1);
    core_exit[127:64] = 64'h5;
    @(negedge clock);
    checkOutput("exit_state", sim_state, 2'd3);
    checkOutput("exit_cause", fail_cause, 2'd1);
    checkOutput("exit_core", fail_core, 1'b1);
    checkOutput("exit_code", fail_exit_code, 64'h5);
    checkOutput("exit_dump", perf_dump, 1'b1);
    core_exit = '0;
    repeat (3) @(negedge clock);
    checkOutput("exit_cause_held", fail_cause, 2'd1);
    checkOutput("exit_code_held", fail_exit_code, 64'h5);

    // Two simultaneous exit errors: lower index wins.
    applyStimulus(64'd0, 32'd0, 64'd0);
    core_step = 16'h0101;
    repeat (3) @(negedge clock);
    core_exit = {64'h9, 64'h7};
    @(negedge clock);
    checkOutput("dual_err_core", fail_core, 1'b0);
    checkOutput("dual_err_code", fail_exit_code, 64'h7);

    // Stuck watchdog on core0 with limit 100 while core1 keeps stepping.
    applyStimulus(64'd0, 32'd100, 64'd0);
    core_step = 16'h0100;
    waitForCycle(64'd100, 200, "stuck_reach100");
    checkOutput("stuck_pre_run", sim_state, 2'd1);
    @(negedge clock);
    checkOutput("stuck_state", sim_state, 2'd3);
    checkOutput("stuck_cause", fail_cause, 2'd2);
    checkOutput("stuck_core", fail_core, 1'b0);
    checkOutput("stuck_code", fail_exit_code, 64'd0);
    checkOutput("stuck_ncycles", n_cycles, 64'd101);

    // Warmup threshold 50 with 6 instructions per cycle.
    applyStimulus(64'd0, 32'd0, 64'd50);
    core_step = 16'h0303;
    pulses = 0;
    pulseInstr = '0;
    for (int i = 0; i < 20; i++) begin
      if (perf_clean) begin
        pulses++;
        pulseInstr = instr_count;
      end
      @(negedge clock);
    end
    checkOutput("warm_pulses", 64'(pulses), 64'd1);
    checkOutput("warm_instr", pulseInstr, 64'd54);

    // Max-cycle watchdog at 1000.
    applyStimulus(64'd1000, 32'd0, 64'd0);
    core_step = 16'h0101;
    waitForCycle(64'd1000, 1100, "max_reach1000");
    checkOutput("max_pre_run", sim_state, 2'd1);
    @(negedge clock);
    checkOutput("max_state", sim_state, 2'd3);
    checkOutput("max_cause", fail_cause, 2'd3);
    checkOutput("max_core", fail_core, 1'b0);
    checkOutput("max_dump", perf_dump, 1'b1);

    // UART: both cores send 20 bytes with the host stalled for 30 cycles.
    applyStimulus(64'd0, 32'd0, 64'd0);
    for (int n = 0; n < 20; n++) begin
      core_uart_valid = 2'b11;
      core_uart_ch    = {8'h80 + 8'(n), 8'(n)};
      @(negedge clock);
    end
    core_uart_valid = '0;
    repeat (10) @(negedge clock);
    checkOutput("uart_head_valid", uart_out_valid, 1'b1);
    checkOutput("uart_head_core", uart_out_core, 1'b1);
    checkOutput("uart_head_ch", uart_out_ch, 8'h80);
    checkOutput("uart_drops", uart_drop_cnt, 16'd22);
    uart_out_ready = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      int idx;
      logic expCore;
      logic [7:0] expCh;
      idx     = (e == 1) ? 0 : e - 2;
      expCore = (e % 2) == 1;
      expCh   = expCore ? (8'h80 + 8'(idx)) : 8'(idx);
      checkOutput("uart_valid", uart_out_valid, 1'b1);
      checkOutput("uart_core", uart_out_core, expCore);
      checkOutput("uart_ch", uart_out_ch, expCh);
      @(negedge clock);
    end
    checkOutput("uart_drained", uart_out_valid, 1'b0);
    checkOutput("uart_drops_final", uart_drop_cnt, 16'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
